// File: rtl/mod_pow2_mul_seq_pkg.sv
// Shared definitions for the sequential modular power-of-two scaler.
// Contents:
//   - default data/modulus width and shift-count width
//   - FSM state encoding shared by the top level
//   - helper giving the width of the doubling intermediate (one carry bit)
package mod_pow2_mul_seq_pkg;

    localparam int BITWIDTH_DEF = 16;
    localparam int SHIFT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Doubling a BITWIDTH value needs one extra bit to hold the carry out.
    function automatic int dbl_width(input int bw);
        return bw + 32'sd1;
    endfunction

endpackage

// File: rtl/mod_pow2_mul_seq_doubler.sv
// mod_doubler: combinational modular doubling, y = (2*x) mod q.
// Ports:
//   x : operand, must satisfy x < q
//   q : modulus
//   y : 2*x mod q
// With x < q < 2^BITWIDTH, 2*x < 2*q, so a single conditional subtract
// brings the result into [0, q-1]. The compare is done at BITWIDTH+1 bits
// so the carry out of the shift is not lost.
module mod_doubler
    import mod_pow2_mul_seq_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] y
);

    localparam int TW = dbl_width(BITWIDTH);

    logic [TW-1:0] t_s;
    logic [TW-1:0] qe_s;
    logic [TW-1:0] diff_s;

    // Shift left into the wide intermediate and reduce once if needed.
    always_comb begin
        t_s    = {x, 1'b0};
        qe_s   = {1'b0, q};
        diff_s = t_s - qe_s;
        if (t_s >= qe_s) begin
            y = diff_s[BITWIDTH-1:0];
        end else begin
            y = t_s[BITWIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_pow2_mul_seq.sv
// mod_pow2_mul_seq: sequential modular scaler, oData = (iData * 2^iShift) mod iQ.
// One modular doubling per clock, valid/ready handshake on both sides.
// Ports:
//   iClk, iRst (sync active-high), iClr (sync abort, below iRst)
//   iValid/oReady : operand handshake (oReady only in IDLE)
//   iData, iQ, iShift : operand, modulus, doubling count (sampled at acceptance)
//   oValid/iReady : result handshake; oData registered, held after pop
//   oBusy  : high while an operation is in RUN or DONE
module mod_pow2_mul_seq
    import mod_pow2_mul_seq_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int SHIFT_W  = SHIFT_W_DEF
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    input  logic [SHIFT_W-1:0]  iShift,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData,
    output logic                oBusy
);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] acc_q,   acc_d;
    logic [BITWIDTH-1:0] q_q,     q_d;
    logic [SHIFT_W-1:0]  count_q, count_d;
    logic                valid_q, valid_d;
    logic [BITWIDTH-1:0] data_q,  data_d;

    logic [BITWIDTH-1:0] pre_s;
    logic [BITWIDTH-1:0] dbl_s;

    mod_doubler #(
        .BITWIDTH (BITWIDTH)
    ) u_doubler (
        .x (acc_q),
        .q (q_q),
        .y (dbl_s)
    );

    // Single pre-reduction of the incoming operand (valid because iData < 2*iQ).
    always_comb begin
        if (iData >= iQ) begin
            pre_s = iData - iQ;
        end else begin
            pre_s = iData;
        end
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        count_d = count_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    q_d     = iQ;
                    count_d = iShift;
                    acc_d   = pre_s;
                    if (iShift != {SHIFT_W{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        // Zero shift: the pre-reduced operand is the result.
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        data_d  = pre_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = dbl_s;
                count_d = count_q - SHIFT_W'(1);
                if (count_q == SHIFT_W'(1)) begin
                    // Last doubling: publish its result directly.
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    data_d  = dbl_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; clear behaves exactly like reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            acc_q   <= {BITWIDTH{1'b0}};
            q_q     <= {BITWIDTH{1'b0}};
            count_q <= {SHIFT_W{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {BITWIDTH{1'b0}};
        end else if (iClr) begin
            state_q <= ST_IDLE;
            acc_q   <= {BITWIDTH{1'b0}};
            q_q     <= {BITWIDTH{1'b0}};
            count_q <= {SHIFT_W{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {BITWIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign oReady = (state_q == ST_IDLE);
    assign oBusy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign oValid = valid_q;
    assign oData  = data_q;

endmodule
